// File: rtl/ecg_phase_sequencer.sv
// Phase sequencer for the ECG datapath: steps a phase index through NUM_PHASES
// phases with per-phase programmable dwell, in single-shot or continuous mode.
module ecg_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int PHASE_W    = 2,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        mode,
    input  logic                        hold,
    input  logic                        abort,
    input  logic [NUM_PHASES*CNT_W-1:0] dwell,
    output logic [PHASE_W-1:0]          phase,
    output logic                        phase_enter,
    output logic [CNT_W-1:0]            elapsed,
    output logic                        busy,
    output logic                        done,
    output logic                        wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t             state;
    logic               mode_q;
    logic [CNT_W-1:0]   dwell_q;
    logic [PHASE_W-1:0] next_phase;
    logic [CNT_W-1:0]   next_dwell;

    // Dwell field of the phase that would be entered at the end of this one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        next_dwell = '0;
        next_phase = (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (next_phase == PHASE_W'(p)) begin
                next_dwell = dwell[p*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            elapsed     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            phase_enter <= 1'b0;
            wrap        <= 1'b0;
            mode_q      <= 1'b0;
            dwell_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
            phase_enter <= 1'b0;
            done        <= 1'b0;
            wrap        <= 1'b0;

            case (state)
                IDLE: begin
                    phase   <= '0;
                    elapsed <= '0;
                    if (start && !abort) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        mode_q      <= mode;
                        dwell_q     <= dwell[CNT_W-1:0];
                        phase_enter <= 1'b1;
                    end
                end

                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        phase   <= '0;
                        elapsed <= '0;
                        busy    <= 1'b0;
                    end else if (hold) begin
                        state <= RUN;
                    end else if (elapsed < dwell_q) begin
                        elapsed <= elapsed + CNT_W'(1);
                    end else begin
                        elapsed <= '0;
                        if (phase != LAST_PHASE) begin
                            phase       <= next_phase;
                            dwell_q     <= next_dwell;
                            phase_enter <= 1'b1;
                        end else if (mode_q) begin
                            phase       <= '0;
                            dwell_q     <= next_dwell;
                            phase_enter <= 1'b1;
                            wrap        <= 1'b1;
                        end else begin
                            state <= IDLE;
                            phase <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ecg_phase_sequencer.md
# ecg_phase_sequencer

Parametrised phase sequencer for the ECG acquisition/processing datapath. It steps a phase index through NUM_PHASES phases, each with a run-time programmable dwell length. Single-shot and continuous modes are supported, with start/abort/hold control and busy/done/phase-entry status. It sits between the top-level control and the sample-processing stages, which decode `phase` to enable their work. With all dwells at 0 and continuous mode selected, it reproduces the earlier free-running 2-bit control counter.

## Interface
- NUM_PHASES, 4, number of phases (2..16)
- PHASE_W, 2, width of `phase`; must satisfy 2^PHASE_W >= NUM_PHASES
- CNT_W, 8, width of each dwell field and of `elapsed`
- clk  input  1  system clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a sequence; honoured only in IDLE
- mode  input  1  0 = single-shot, 1 = continuous; sampled with `start`
- hold  input  1  freeze phase and dwell counter while high (RUN only)
- abort  input  1  return to IDLE next edge; no `done` pulse
- dwell  input  NUM_PHASES*CNT_W  field p = dwell[p*CNT_W +: CNT_W]; phase p lasts field+1 non-held cycles
- phase  output  PHASE_W  current phase index
- phase_enter  output  1  one-cycle pulse on the first cycle of every phase (including re-entry of phase 0 on wrap)
- elapsed  output  CNT_W  non-held cycles already spent in current phase
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the final phase of a single-shot sequence
- wrap  output  1  one-cycle pulse when continuous mode wraps from NUM_PHASES-1 to 0

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset (async on `rst_n` low, released synchronously by design): IDLE, phase=0, elapsed=0, busy=0, done=0, phase_enter=0, wrap=0, latched mode=0, latched dwell=0.
- IDLE: phase=0, elapsed=0. When `start`=1 and `abort`=0 → RUN. Latch `mode`. Latch dwell field 0. Set phase=0, elapsed=0, phase_enter=1.
- RUN, priority abort > hold > advance:
  - abort=1: → IDLE; phase=0, elapsed=0, busy=0; done=0, wrap=0.
  - hold=1: phase, elapsed and state unchanged; phase_enter, done and wrap are 0 during held cycles.
  - Otherwise, if elapsed < latched dwell: elapsed+1.
  - Otherwise (end of phase): elapsed=0.
    - If phase < NUM_PHASES-1: phase+1, latch that phase's dwell field, phase_enter=1.
    - If phase = NUM_PHASES-1 and mode=1: phase=0, latch field 0, phase_enter=1, wrap=1.
    - If phase = NUM_PHASES-1 and mode=0: → IDLE, phase=0, busy=0, done=1.
- Dwell latching: each dwell field is latched on phase entry. Changes to `dwell` mid-phase affect only later entries.
- `start` in RUN is ignored. `mode` changes in RUN are ignored.
- Dwell=0 gives a 1-cycle phase. Dwell = 2^CNT_W-1 gives 2^CNT_W cycles; `elapsed` never overflows.
- Simultaneous start and abort in IDLE: stay IDLE.
- abort on the end-of-phase cycle of the final single-shot phase: abort wins, no done pulse.

## Timing
- `start` sampled at edge k → busy=1, phase=0, phase_enter=1 visible after edge k.
- Phase p with no holds: d_p+1 cycles. Each held cycle adds one cycle.
- Single-shot busy duration with no holds: sum over p of (d_p+1) cycles. `done`=1 on the first cycle after busy falls; a new `start` is accepted in that same cycle.
- Continuous mode: period is sum(d_p+1) cycles. `wrap` and `phase_enter` coincide with phase returning to 0.
- Abort latency: 1 edge.
- Reset assertion mid-sequence: outputs reach reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, continuous, NUM_PHASES=4, all dwell=0, start pulse:
  - phase sequence 0,1,2,3,0,1… one per cycle;
  - phase_enter high every cycle;
  - wrap on every 4th cycle.
- Single-shot, dwell={3,0,2,1} (phase 0..3), start at cycle 0:
  - busy for 4+1+3+2=10 cycles;
  - phase_enter at cycles 0,4,5,8;
  - done one cycle after busy falls; phase returns to 0.
- Single-shot, all dwell=2, hold high for 3 cycles when phase=1 and elapsed=1:
  - elapsed stays 1 throughout the hold;
  - busy totals 12+3=15 cycles;
  - no phase_enter during the hold.
- Continuous, all dwell=1, abort when phase=2:
  - next cycle busy=0, phase=0, no done, no wrap;
  - a subsequent start restarts from phase 0.
- Single-shot running; change `dwell` field 1 from 5 to 0 while in phase 1 and assert `start` again:
  - phase 1 still lasts 6 cycles; the second start is ignored;
  - a second sequence started after done uses the new value (1 cycle).
- Drive rst_n low asynchronously mid-phase 3, between clock edges:
  - all outputs reach reset values before the next edge;
  - with start held low after rst_n rises, the block stays IDLE.
